// File: rtl/seg7_scan_mux.sv
// Purpose: time-multiplexed scanner for a multi-digit 7-segment display. It feeds the hex decoder one nibble and one dp bit per digit slot and drives the one-hot digit enables.
// Latency: all outputs are decoded from registers. New data takes effect at the next frame boundary. blankLeadIn takes effect one cycle after it changes.
// Backpressure: none. loadIn is always accepted. The last load in a frame wins, and a load on the boundary edge is committed directly.
//
// Ports:
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   dataIn       : 4*DIGITS nibbles, digit 0 in [3:0] (rightmost)
//   dpMaskIn     : decimal point per digit, bit i = digit i
//   loadIn       : capture dataIn/dpMaskIn for the next frame
//   blankLeadIn  : enable leading-zero blanking (not frame-buffered)
//   valOut/dpOut : nibble and decimal point for the decoder
//   blankOut     : current digit is blanked
//   digitSel     : one-hot digit enable, zero during guard or blank
//   frameOut     : one-cycle pulse on the first cycle of each new frame
module seg7_scan_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int GUARD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   dataIn,
    input  logic [DIGITS-1:0]     dpMaskIn,
    input  logic                  loadIn,
    input  logic                  blankLeadIn,
    output logic [3:0]            valOut,
    output logic                  dpOut,
    output logic                  blankOut,
    output logic [DIGITS-1:0]     digitSel,
    output logic                  frameOut
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    // Scan position
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;

    // Displayed (active) and pending (next-frame) buffers
    logic [4*DIGITS-1:0]    act_dat_q, act_dat_d;
    logic [DIGITS-1:0]      act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0]    pend_dat_q, pend_dat_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic                   pend_vld_q, pend_vld_d;

    // Frame pulse, reset-hold flag, registered blanking enable
    logic                   frame_q, frame_d;
    logic                   hold_q, hold_d;
    logic                   blk_en_q, blk_en_d;

    logic                   boundary;

    // hold_q marks "reset in effect". The first edge with rst low only clears it,
    // so that edge starts cycle 0 with cnt and idx still at zero.
    assign boundary = !hold_q && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        act_dat_d  = act_dat_q;
        act_dp_d   = act_dp_q;
        pend_dat_d = pend_dat_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        frame_d    = boundary;
        hold_d     = 1'b0;
        blk_en_d   = blankLeadIn;

        if (!hold_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (boundary) begin
            // A load on the boundary edge itself is newer than anything pending.
            if (loadIn) begin
                act_dat_d = dataIn;
                act_dp_d  = dpMaskIn;
            end else if (pend_vld_q) begin
                act_dat_d = pend_dat_q;
                act_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (loadIn) begin
            pend_dat_d = dataIn;
            pend_dp_d  = dpMaskIn;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_dat_q  <= '0;
            act_dp_q   <= '0;
            pend_dat_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= 1'b0;
            hold_q     <= 1'b1;
            blk_en_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_dat_q  <= act_dat_d;
            act_dp_q   <= act_dp_d;
            pend_dat_q <= pend_dat_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= frame_d;
            hold_q     <= hold_d;
            blk_en_q   <= blk_en_d;
        end
    end

    // zero_from[i]: digits i..DIGITS-1 all have a zero nibble and no dp.
    logic [DIGITS:0]  zero_from;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             blank;

    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (act_dat_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = act_dat_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
            end
        end
    end

    // Digit 0 always shows, so a zero value still displays a single "0".
    assign blank = blk_en_q && (idx_q != '0) && zero_from[idx_q];

    assign valOut   = (hold_q || blank) ? 4'h0 : cur_nib;
    assign dpOut    = !hold_q && !blank && cur_dp;
    assign blankOut = !hold_q && blank;
    assign digitSel = (!hold_q && !blank && (cnt_q >= GUARD_C)) ? (DIGITS'(1) << idx_q) : '0;
    assign frameOut = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Purpose: directed checks of seg7_scan_mux (DIGITS=4, DIV=8, GUARD=2), covering scan, buffering, blanking and reset.
// Latency: checks every output on the falling edge of every cycle of each listed frame.
// Backpressure: not applicable.
module tb_seg7_scan_mux;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dataIn = 16'hEEEE;
    logic [3:0]  dpMaskIn = 4'hF;
    logic        loadIn = 1'b0;
    logic        blankLeadIn = 1'b0;
    logic [3:0]  valOut;
    logic        dpOut;
    logic        blankOut;
    logic [3:0]  digitSel;
    logic        frameOut;

    int vectors = 0;
    int miscompares = 0;
    int cyc = -1;

    always #5 clk = ~clk;

    // Cycle 0 is the cycle that follows the first edge which samples rst low.
    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    seg7_scan_mux #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rst         (rst),
        .dataIn      (dataIn),
        .dpMaskIn    (dpMaskIn),
        .loadIn      (loadIn),
        .blankLeadIn (blankLeadIn),
        .valOut      (valOut),
        .dpOut       (dpOut),
        .blankOut    (blankOut),
        .digitSel    (digitSel),
        .frameOut    (frameOut)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        int n;
        n = 0;
        while (cyc != c && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) begin
            vectors++;
            miscompares++;
            $error("FAIL wait_cyc observed=%0d expected=%0d", cyc, c);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_val"}, cyc, valOut, 0);
        chk({tag, "_dp"}, cyc, dpOut, 0);
        chk({tag, "_blank"}, cyc, blankOut, 0);
        chk({tag, "_sel"}, cyc, digitSel, 0);
        chk({tag, "_frame"}, cyc, frameOut, 0);
    endtask

    // Checks cycles c0..c0+ncyc-1 of a frame starting at c0.
    // ev: nibble per slot, eon: digitSel per slot in the ON phase,
    // eblk/edp: blankOut/dpOut per slot, efr: frameOut expected at c0.
    // Loads la/lb are driven during the given cycles.
    task automatic run_frame(input int c0, input int ncyc,
                             input logic [15:0] ev, input logic [15:0] eon,
                             input logic [3:0] eblk, input logic [3:0] edp, input bit efr,
                             input int la, input logic [15:0] lda, input logic [3:0] ldpa,
                             input int lb, input logic [15:0] ldb, input logic [3:0] ldpb);
        for (int c = c0; c < c0 + ncyc; c++) begin
            int s;
            int k;
            s = (c - c0) / DIV;
            k = (c - c0) % DIV;
            wait_cyc(c);
            chk("valOut", c, valOut, ev[4*s +: 4]);
            chk("dpOut", c, dpOut, edp[s]);
            chk("blankOut", c, blankOut, eblk[s]);
            chk("digitSel", c, digitSel, (k < GUARD) ? 4'h0 : eon[4*s +: 4]);
            chk("frameOut", c, frameOut, (efr && c == c0) ? 1 : 0);
            if (c == la) begin
                loadIn = 1'b1; dataIn = lda; dpMaskIn = ldpa;
            end else if (c == lb) begin
                loadIn = 1'b1; dataIn = ldb; dpMaskIn = ldpb;
            end else begin
                loadIn = 1'b0; dataIn = 16'hEEEE; dpMaskIn = 4'hF;
            end
        end
    endtask

    initial begin
        // Reset held for three edges; outputs must be zero throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero("reset");
        end
        rst = 1'b0;

        // Frame 0: nothing active yet; load 0x1234 in cycle 5.
        run_frame(0,   32, 16'h0000, 16'h8421, 4'b0000, 4'b0000, 1'b0,
                  5,   16'h1234, 4'h0,  -1, 16'h0, 4'h0);
        // Frame 1: shows 4,3,2,1; loads 0x1111 then 0x2222 (last wins).
        run_frame(32,  32, 16'h1234, 16'h8421, 4'b0000, 4'b0000, 1'b1,
                  42,  16'h1111, 4'h0,  52, 16'h2222, 4'h0);
        // Frame 2: shows 2s; pending 0x4444 overridden by boundary-edge load of 0x3333.
        run_frame(64,  32, 16'h2222, 16'h8421, 4'b0000, 4'b0000, 1'b1,
                  70,  16'h4444, 4'h0,  95, 16'h3333, 4'h0);
        // Frame 3: shows 3s; stage 0x0050 for blanking.
        run_frame(96,  32, 16'h3333, 16'h8421, 4'b0000, 4'b0000, 1'b1,
                  99,  16'h0050, 4'h0,  -1, 16'h0, 4'h0);
        blankLeadIn = 1'b1;
        // Frame 4: 0x0050 blanked above digit 1.
        run_frame(128, 32, 16'h0050, 16'h0021, 4'b1100, 4'b0000, 1'b1,
                  130, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
        // Frame 5: dp on digit 3 prevents all blanking.
        run_frame(160, 32, 16'h0050, 16'h8421, 4'b0000, 4'b1000, 1'b1,
                  165, 16'h0000, 4'h0,  -1, 16'h0, 4'h0);
        // Frame 6: all zero, only digit 0 lit.
        run_frame(192, 32, 16'h0000, 16'h0001, 4'b1110, 4'b0000, 1'b1,
                  200, 16'h1234, 4'b0101, -1, 16'h0, 4'h0);
        // Frame 7 (partial): 0x1234 with dp 0101; load 0x9999 then reset mid-frame.
        run_frame(224, 14, 16'h1234, 16'h8421, 4'b0000, 4'b0101, 1'b1,
                  232, 16'h9999, 4'hF,  -1, 16'h0, 4'h0);
        rst = 1'b1;
        blankLeadIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_zero("midreset");
        end
        rst = 1'b0;
        // After reset: pending 0x9999 discarded, scan restarts at digit 0.
        run_frame(0,   32, 16'h0000, 16'h8421, 4'b0000, 4'b0000, 1'b0,
                  -1,  16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame(32,  8,  16'h0000, 16'h8421, 4'b0000, 4'b0000, 1'b1,
                  -1,  16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
